regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 126 ++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with two write ports, two read ports and a busy scoreboard
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [AW-1:0]     waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [AW-1:0]     waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rbusy1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy2,
    input  logic              set_busy,
    input  logic [AW-1:0]     set_addr,
    output logic [NREG-1:0]   busy_vec
);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic              wr0_ok;
    logic              wr1_ok;
    logic              set_ok;

    // Writes and marks aimed at the hardwired zero register are dropped up front.
    assign wr0_ok = we0 && !(ZERO_REG != 0 && waddr0 == '0);
    assign wr1_ok = we1 && !(ZERO_REG != 0 && waddr1 == '0);
    assign set_ok = set_busy && !(ZERO_REG != 0 && set_addr == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr1_ok && waddr1 == AW'(i)) begin
                    regs[i] <= wdata1;
                end else if (wr0_ok && waddr0 == AW'(i)) begin
                    regs[i] <= wdata0;
                end
            end
        end
    end

    // Clears from completing writes first, then the new producer's mark so it wins a collision.
    always_comb begin
        busy_d = busy_q;
        if (we0) begin
            busy_d[waddr0] = 1'b0;
        end
        if (we1) begin
            busy_d[waddr1] = 1'b0;
        end
        if (set_ok) begin
            busy_d[set_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [AW-1:0]     ra;
        logic              zero_hit;
        logic              hit0;
        logic              hit1;
        logic              set_hit;
        logic [DATA_W-1:0] rd_val;
        logic              rb_val;

        assign ra = (p == 0) ? raddr1 : raddr2;

        always_comb begin
            zero_hit = (ZERO_REG != 0) && (ra == '0);
            hit1     = (BYPASS != 0) && we1 && (waddr1 == ra) && !zero_hit;
            hit0     = (BYPASS != 0) && we0 && (waddr0 == ra) && !zero_hit;
            set_hit  = set_busy && (set_addr == ra);
            rd_val   = regs[ra];
            rb_val   = busy_q[ra];
            if (!rst) begin
                rd_val = '0;
                rb_val = 1'b0;
            end else if (zero_hit) begin
                rd_val = '0;
                rb_val = 1'b0;
            end else begin
                if (hit1) begin
                    rd_val = wdata1;
                end else if (hit0) begin
                    rd_val = wdata0;
                end
                // A forwarded value is already available unless a new producer claims it this cycle.
                if ((hit0 || hit1) && !set_hit) begin
                    rb_val = 1'b0;
                end
            end
        end
    end

    assign rdata1 = g_rd[0].rd_val;
    assign rbusy1 = g_rd[0].rb_val;
    assign rdata2 = g_rd[1].rd_val;
    assign rbusy2 = g_rd[1].rb_val;

endmodule
